avl_mm_rr_arbiter: RTL

- Parametrised N-master to 1-slave Avalon-MM pipelined-read arbiter.
- Next generation of the fixed imem/dmem-to-shared-slave arrangement in the Qsys system.
- Any number of CPU or DMA masters share one SDRAM or bridge slave.
- Round-robin grant, command lock while the slave stalls, and in-order readdatavalid routing through an outstanding-read ID FIFO.

---
 rtl/avl_mm_rr_arbiter_if.sv | 40 ++++
 rtl/avl_mm_rr_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/avl_mm_rr_arbiter_if.sv
// rtl/avl_mm_rr_arbiter_if.sv - N-master / 1-slave Avalon-MM pipelined-read bus bundle.
interface avl_mm_rr_arbiter_if #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  logic [N_MASTERS-1:0]          m_read;
  logic [N_MASTERS-1:0]          m_write;
  logic [N_MASTERS*ADDR_W-1:0]   m_address;
  logic [N_MASTERS*DATA_W-1:0]   m_writedata;
  logic [N_MASTERS*DATA_W/8-1:0] m_byteenable;
  logic [N_MASTERS-1:0]          m_waitrequest;
  logic [DATA_W-1:0]             m_readdata;
  logic [N_MASTERS-1:0]          m_readdatavalid;
  logic [1:0]                    m_response;
  logic                          s_read;
  logic                          s_write;
  logic [ADDR_W-1:0]             s_address;
  logic [DATA_W-1:0]             s_writedata;
  logic [DATA_W/8-1:0]           s_byteenable;
  logic                          s_waitrequest;
  logic [DATA_W-1:0]             s_readdata;
  logic                          s_readdatavalid;
  logic [1:0]                    s_response;

  // slave: the arbiter's view; master: the masters plus the downstream slave
  modport slave (
    input  m_read, m_write, m_address, m_writedata, m_byteenable,
           s_waitrequest, s_readdata, s_readdatavalid, s_response,
    output m_waitrequest, m_readdata, m_readdatavalid, m_response,
           s_read, s_write, s_address, s_writedata, s_byteenable
  );

  modport master (
    output m_read, m_write, m_address, m_writedata, m_byteenable,
           s_waitrequest, s_readdata, s_readdatavalid, s_response,
    input  m_waitrequest, m_readdata, m_readdatavalid, m_response,
           s_read, s_write, s_address, s_writedata, s_byteenable
  );
endinterface

// File: rtl/avl_mm_rr_arbiter.sv
// rtl/avl_mm_rr_arbiter.sv - Round-robin N:1 Avalon-MM arbiter with command lock
// and in-order read-data routing through an outstanding-read ID FIFO.
module avl_mm_rr_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_PEND  = 4
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset,
  avl_mm_rr_arbiter_if.slave            bus,
  output logic [$clog2(MAX_PEND+1)-1:0] pend_count,
  output logic                          err_unexp_rdv
);
  localparam int IDW = $clog2(N_MASTERS);
  localparam int PW  = $clog2(MAX_PEND);
  localparam int CW  = $clog2(MAX_PEND+1);
  localparam int BEW = DATA_W/8;

  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_lock_id;
  logic           r_locked;
  logic [IDW-1:0] r_fifo [MAX_PEND];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           r_err;

  logic [N_MASTERS-1:0]   w_req;
  logic [N_MASTERS-1:0]   w_elig;
  logic [2*N_MASTERS-1:0] w_rot2;
  logic [N_MASTERS-1:0]   w_rot;
  logic [IDW-1:0]         w_off;
  logic [IDW:0]           w_sum;
  logic [IDW-1:0]         w_scan_id;
  logic [IDW-1:0]         w_gnt_id;
  logic [IDW-1:0]         w_next_ptr;
  logic [IDW-1:0]         w_head;
  logic w_full, w_empty, w_gnt_valid, w_is_read, w_is_write;
  logic w_accept, w_push, w_pop;

  assign w_req   = bus.m_read | bus.m_write;
  assign w_full  = (r_count == CW'(MAX_PEND));
  assign w_empty = (r_count == '0);
  // A full FIFO removes reads from arbitration; writes are never blocked
  assign w_elig  = bus.m_write | (bus.m_read & {N_MASTERS{~w_full}});

  // Rotate so the pointer sits at bit 0, then take the lowest set bit as the offset
  assign w_rot2 = {w_elig, w_elig} >> r_ptr;
  assign w_rot  = w_rot2[N_MASTERS-1:0];

  always_comb begin
    w_off = '0;
    for (int k = N_MASTERS-1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IDW'(k);
    end
  end

  assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_scan_id = (w_sum >= (IDW+1)'(N_MASTERS)) ? IDW'(w_sum - (IDW+1)'(N_MASTERS))
                                                    : w_sum[IDW-1:0];

  assign w_gnt_id    = r_locked ? r_lock_id : w_scan_id;
  assign w_gnt_valid = ~reset_reset & (r_locked ? w_req[r_lock_id] : |w_elig);
  assign w_is_write  = w_gnt_valid & bus.m_write[w_gnt_id];
  assign w_is_read   = w_gnt_valid & bus.m_read[w_gnt_id] & ~bus.m_write[w_gnt_id];
  assign w_accept    = w_gnt_valid & ~bus.s_waitrequest;
  assign w_push      = w_accept & w_is_read;
  assign w_pop       = bus.s_readdatavalid & ~w_empty;
  assign w_next_ptr  = (w_gnt_id == IDW'(N_MASTERS-1)) ? '0 : w_gnt_id + 1'b1;
  assign w_head      = r_fifo[r_rd_ptr];

  assign bus.s_read      = w_is_read;
  assign bus.s_write     = w_is_write;
  assign bus.m_readdata  = bus.s_readdata;
  assign bus.m_response  = bus.s_response;
  assign pend_count      = r_count;
  assign err_unexp_rdv   = r_err;

  always_comb begin
    bus.s_address       = '0;
    bus.s_writedata     = '0;
    bus.s_byteenable    = '0;
    bus.m_waitrequest   = '1;
    bus.m_readdatavalid = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (w_gnt_id == IDW'(i)) begin
        bus.s_address    = bus.m_address[i*ADDR_W +: ADDR_W];
        bus.s_writedata  = bus.m_writedata[i*DATA_W +: DATA_W];
        bus.s_byteenable = bus.m_byteenable[i*BEW +: BEW];
        if (w_gnt_valid) bus.m_waitrequest[i] = bus.s_waitrequest;
      end
      if (w_pop && (w_head == IDW'(i))) bus.m_readdatavalid[i] = 1'b1;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_ptr     <= '0;
      r_lock_id <= '0;
      r_locked  <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
    end else begin
      // Lock holds a stalled command's owner until the slave takes it
      r_locked <= w_gnt_valid & bus.s_waitrequest;
      if (w_gnt_valid & bus.s_waitrequest) r_lock_id <= w_gnt_id;
      if (w_accept) r_ptr <= w_next_ptr;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop) r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (bus.s_readdatavalid && w_empty) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_gnt_id;
  end
endmodule
